period_capture: RTL and testbench
=================================

Name: period_capture

Overview:
- Measures the period of an external pulse train in clk cycles by counting up between consecutive rising edges of sig_in.
- Each completed period is reported with a one-cycle valid strobe.
- Complements the programmable down-counter timer: that block generates intervals, this block measures them. It is used to verify and calibrate the timer's wrap output and other periodic signals.

Parameters:
- width, 16, bit width of the internal counter and of the period output; maximum reportable period is 2^width-1 cycles.

Ports:
- clk  input  1  system clock; all state updates on the falling edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  measurement enable; low forces IDLE.
- sig_in  input  1  signal to measure; may be asynchronous to clk.
- period  output  width  last captured period in clk cycles.
- valid  output  1  one-cycle pulse, high in the cycle after period/ovf update.
- ovf  output  1  captured period saturated (true period > 2^width-1); updated together with period.
- busy  output  1  high while in MEASURE state.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, period=0, valid=0, ovf=0, busy=0, synchronizer flops s1=s2=s3=0.
- Synchronizer: s1<=sig_in, s2<=s1, s3<=s2 on every falling edge, independent of en.
- Rise detection: rise = s2 & ~s3.
  - If sig_in is high at falling edge N (and was low at N-1), rise is true in the cycle after edge N+1.
  - The rise is acted on at edge N+2.
- Counter cnt (width bits):
  - Saturating increment: cnt+1 unless cnt == all-ones, in which case it holds.
  - sat flag set when an increment is attempted at all-ones; sat is cleared whenever cnt is reloaded.
- States: IDLE, MEASURE.
- IDLE:
  - busy=0; cnt held at 0; sat=0.
  - If en=1 and rise: go to MEASURE, cnt<=1, no valid. This first edge only arms the block.
  - Otherwise stay in IDLE.
- MEASURE:
  - busy=1.
  - en=0: go to IDLE, cnt<=0, sat<=0, no capture. en=0 wins over a simultaneous rise.
  - rise: period<=cnt, ovf<=sat, valid<=1 for exactly one cycle, cnt<=1, sat<=0, remain in MEASURE.
  - Otherwise: saturating increment of cnt.
- Period arithmetic: consecutive rising edges P clk cycles apart give period=P, for 1 < P <= 2^width-1. If P > 2^width-1, then period=2^width-1 and ovf=1.
- Minimum measurable spacing is 2 cycles (sig_in high one cycle, low one cycle). Narrower pulses may be missed; this is not an error.
- valid is low on every cycle other than the one following a capture edge.
- period and ovf hold their last captured values until the next capture. They are not cleared by en=0; only rst clears them.
- Reset mid-measurement: everything returns to reset values immediately; the next capture needs two rising edges after rst and en are high.
- sig_in held constant (high or low): no rise, no valid; cnt saturates at all-ones and stays there.

Test Plan:
- Reset check: assert rst=0 mid-run with sig_in toggling -> period=0, valid=0, ovf=0, busy=0 immediately, asynchronously to clk.
- Basic period: width=16, en=1, sig_in square wave, period 10 cycles, duty 50%, 4 rising edges -> three valid pulses each with period=10, ovf=0; busy=1 from the first rise onward; no valid on the first edge.
- Arming latency: sig_in rises before edge N -> busy goes high at edge N+2; the second rise P=7 later -> valid high after edge N+9, period=7.
- Saturation: width=4, sig_in rises 20 cycles apart -> period=15, ovf=1. A following 5-cycle interval -> period=5, ovf=0.
- Enable abort: en drops 3 cycles before an expected rise, then returns -> no valid for that interval; the first rise after re-enable only arms; the next interval is reported correctly. en falling at the same edge as a rise -> IDLE, no valid.
- Minimum spacing: 1-high/1-low toggling -> every valid reports period=2, ovf=0. A constant-high sig_in for 100 cycles -> no valid, period unchanged.

Source files
------------

// File: rtl/period_capture.sv
`default_nettype none
// ============================================================================
//  Module   : period_capture
//  Purpose  : Measures the spacing, in clk cycles, between consecutive rising
//             edges of sig_in and reports each completed period with a
//             one-cycle valid strobe. The first edge after enabling only arms
//             the measurement. All state updates on the falling clk edge.
//  Ports    : clk    - system clock (state updates on negedge)
//             rst    - asynchronous active-low reset
//             en     - measurement enable; low returns the block to IDLE
//             sig_in - signal to measure, may be asynchronous to clk
//             period - last captured period (saturates at 2^WIDTH-1)
//             valid  - one-cycle strobe following each period/ovf update
//             ovf    - captured period saturated
//             busy   - high while measuring
//  Revision : 1.0 - initial release
// ============================================================================
module period_capture #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  localparam logic [0:0]       ST_IDLE    = 1'b0;
  localparam logic [0:0]       ST_MEASURE = 1'b1;
  localparam logic [WIDTH-1:0] CNT_ZERO   = '0;
  localparam logic [WIDTH-1:0] CNT_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  // Three-flop chain: s1/s2 resynchronise sig_in, s3 is the delayed copy
  // used for edge detection.
  logic             s1_q, s2_q, s3_q;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic             rise_w;
  logic             cnt_max_w;

  assign rise_w    = s2_q & ~s3_q;
  assign cnt_max_w = &cnt_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        sat_d = 1'b0;
        // The first edge only starts the count; there is no interval yet.
        if (en && rise_w) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_ONE;
        end
      end
      ST_MEASURE: begin
        // Disable takes priority over a coincident edge: nothing is captured.
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          sat_d   = 1'b0;
        end else if (rise_w) begin
          period_d = cnt_q;
          ovf_d    = sat_q;
          valid_d  = 1'b1;
          cnt_d    = CNT_ONE;
          sat_d    = 1'b0;
        end else if (cnt_max_w) begin
          // Hold at all-ones and remember that the true period is longer.
          sat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        sat_d   = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      sat_q    <= 1'b0;
      period_q <= CNT_ZERO;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign period = period_q;
  assign valid  = valid_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q == ST_MEASURE);

endmodule
`default_nettype wire

// File: tb/tb_period_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_period_capture
//  Purpose  : Directed self-checking bench for period_capture. A 16-bit and a
//             4-bit instance share the same stimulus so that saturation can be
//             observed on the narrow one while the wide one reports the true
//             spacing. Inputs are driven and outputs sampled 1 time unit after
//             the rising clk edge, away from the falling edge the DUT uses.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_period_capture;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sig_in;

  logic [15:0] period16;
  logic        valid16, ovf16, busy16;
  logic [3:0]  period4;
  logic        valid4, ovf4, busy4;

  int n_checks = 0;
  int n_errors = 0;

  int   vcnt16 = 0;
  int   vcnt4  = 0;
  int   psum16 = 0;
  int   dbl16  = 0;
  logic prev16 = 1'b0;
  int   snap;
  int   snap_sum;

  period_capture #(.WIDTH(16)) u_dut16 (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sig_in (sig_in),
    .period (period16),
    .valid  (valid16),
    .ovf    (ovf16),
    .busy   (busy16)
  );

  period_capture #(.WIDTH(4)) u_dut4 (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sig_in (sig_in),
    .period (period4),
    .valid  (valid4),
    .ovf    (ovf4),
    .busy   (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Valid-strobe monitor: counts strobes, sums reported periods and counts
  // strobes that stay high for more than one cycle.
  always @(posedge clk) begin
    if (valid16) begin
      vcnt16 <= vcnt16 + 1;
      psum16 <= psum16 + int'(period16);
    end
    if (valid16 && prev16) dbl16 <= dbl16 + 1;
    prev16 <= valid16;
    if (valid4) vcnt4 <= vcnt4 + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle high pulse; the next pulse_gap call starts a rise exactly
  // 'gap' cycles after this one.
  task automatic pulse_gap(input int gap);
    sig_in = 1'b1;
    cyc(1);
    sig_in = 1'b0;
    cyc(gap - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    sig_in = 1'b0;
    #1 rst = 1'b0;
    cyc(3);

    // Reset state
    check_val("rst_period16", period16, 0);
    check_val("rst_valid16",  valid16,  0);
    check_val("rst_ovf16",    ovf16,    0);
    check_val("rst_busy16",   busy16,   0);
    check_val("rst_period4",  period4,  0);
    rst = 1'b1;
    cyc(2);

    // Basic: 10-cycle square wave, 4 rising edges -> 3 captures of 10
    en = 1'b1;
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      sig_in = 1'b1;
      cyc(5);
      sig_in = 1'b0;
      cyc(5);
      if (i == 0) begin
        check_val("basic_first_edge_no_valid", vcnt16, 0);
        check_val("basic_busy_after_arm",      busy16, 1);
      end
    end
    check_val("basic_valid_count", vcnt16, 3);
    check_val("basic_period_sum",  psum16, 30);
    check_val("basic_period16",    period16, 10);
    check_val("basic_ovf16",       ovf16, 0);
    check_val("basic_period4",     period4, 10);
    check_val("basic_valid_count4", vcnt4, 3);

    // Arming latency: rise at edge N -> busy at N+2; next rise 7 later -> valid after N+9
    en = 1'b0;
    cyc(3);
    en = 1'b1;
    cyc(3);
    sig_in = 1'b1;
    cyc(1);
    check_val("arm_busy_after_N",  busy16, 0);
    cyc(1);
    check_val("arm_busy_after_N1", busy16, 0);
    cyc(1);
    check_val("arm_busy_after_N2", busy16, 1);
    sig_in = 1'b0;
    cyc(4);
    sig_in = 1'b1;
    cyc(2);
    check_val("arm_valid_after_N8", valid16, 0);
    cyc(1);
    check_val("arm_valid_after_N9", valid16, 1);
    check_val("arm_period7",        period16, 7);
    cyc(1);
    check_val("arm_valid_one_cycle", valid16, 0);
    sig_in = 1'b0;

    // Saturation on the 4-bit instance
    en = 1'b0;
    cyc(3);
    en = 1'b1;
    cyc(3);
    pulse_gap(20);
    pulse_gap(5);
    check_val("sat20_period4",  period4, 15);
    check_val("sat20_ovf4",     ovf4, 1);
    check_val("sat20_period16", period16, 20);
    check_val("sat20_ovf16",    ovf16, 0);
    pulse_gap(15);
    check_val("sat5_period4",   period4, 5);
    check_val("sat5_ovf4",      ovf4, 0);
    check_val("sat5_period16",  period16, 5);
    pulse_gap(16);
    check_val("sat15_period4",  period4, 15);
    check_val("sat15_ovf4",     ovf4, 0);
    pulse_gap(3);
    check_val("sat16_period4",  period4, 15);
    check_val("sat16_ovf4",     ovf4, 1);
    check_val("sat16_period16", period16, 16);
    pulse_gap(4);
    check_val("p3_period16",    period16, 3);

    // Enable abort: en drops 3 cycles before the expected rise
    pulse_gap(10);
    check_val("p4_period16", period16, 4);
    sig_in = 1'b1;
    cyc(1);
    sig_in = 1'b0;
    cyc(6);
    check_val("abort_pre_period16", period16, 10);
    snap = vcnt16;
    en = 1'b0;
    cyc(3);
    sig_in = 1'b1;
    cyc(1);
    sig_in = 1'b0;
    cyc(4);
    check_val("abort_busy_low",   busy16, 0);
    check_val("abort_no_valid",   vcnt16, snap);
    check_val("abort_period_kept", period16, 10);
    en = 1'b1;
    cyc(5);
    pulse_gap(9);
    check_val("rearm_no_valid", vcnt16, snap);
    check_val("rearm_busy",     busy16, 1);
    pulse_gap(5);
    check_val("rearm_valid_count", vcnt16, snap + 1);
    check_val("rearm_period16",    period16, 9);

    // en falling at the same edge the rise is acted on
    sig_in = 1'b1;
    cyc(1);
    sig_in = 1'b0;
    cyc(1);
    en = 1'b0;
    cyc(3);
    check_val("en_rise_same_edge_no_valid", vcnt16, snap + 1);
    check_val("en_rise_same_edge_busy",     busy16, 0);
    check_val("en_rise_same_edge_period",   period16, 9);
    en = 1'b1;
    cyc(3);

    // Minimum spacing: 1-high/1-low toggling, 10 rises -> 9 captures of 2
    snap     = vcnt16;
    snap_sum = psum16;
    for (int i = 0; i < 10; i++) begin
      sig_in = 1'b1;
      cyc(1);
      sig_in = 1'b0;
      cyc(1);
    end
    cyc(2);
    check_val("min_valid_count", vcnt16 - snap, 9);
    check_val("min_period_sum",  psum16 - snap_sum, 18);
    check_val("min_period16",    period16, 2);
    check_val("min_ovf16",       ovf16, 0);
    check_val("min_period4",     period4, 2);
    check_val("min_ovf4",        ovf4, 0);
    check_val("valid_never_double", dbl16, 0);

    // Constant-high input: one capture for the entering edge, then nothing
    sig_in = 1'b1;
    cyc(4);
    check_val("const_first_capture", period16, 4);
    snap = vcnt16;
    cyc(100);
    check_val("const_no_valid",    vcnt16, snap);
    check_val("const_period_kept", period16, 4);
    check_val("const_busy",        busy16, 1);

    // Asynchronous reset in the middle of a valid strobe
    sig_in = 1'b0;
    cyc(20);
    sig_in = 1'b1;
    cyc(1);
    sig_in = 1'b0;
    cyc(2);
    check_val("pre_rst_valid16",  valid16, 1);
    check_val("pre_rst_period16", period16, 124);
    check_val("pre_rst_ovf4",     ovf4, 1);
    #1 rst = 1'b0;
    #1;
    check_val("async_rst_valid16",  valid16, 0);
    check_val("async_rst_period16", period16, 0);
    check_val("async_rst_ovf4",     ovf4, 0);
    check_val("async_rst_busy16",   busy16, 0);
    check_val("async_rst_period4",  period4, 0);
    cyc(2);
    rst = 1'b1;
    snap = vcnt16;
    pulse_gap(6);
    check_val("post_rst_arm_no_valid", vcnt16, snap);
    check_val("post_rst_busy",         busy16, 1);
    pulse_gap(6);
    check_val("post_rst_valid_count", vcnt16, snap + 1);
    check_val("post_rst_period16",    period16, 6);
    check_val("post_rst_ovf4",        ovf4, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
